// File: rtl/uriscv_defs_pkg.sv
// Shared definitions for the uriscv multiply/divide unit.
// The op codes are RISC-V funct3 values. The state type covers the iterative sequencer.
package uriscv_defs;

    localparam logic [2:0] MULDIV_OP_MUL    = 3'd0;
    localparam logic [2:0] MULDIV_OP_MULH   = 3'd1;
    localparam logic [2:0] MULDIV_OP_MULHSU = 3'd2;
    localparam logic [2:0] MULDIV_OP_MULHU  = 3'd3;
    localparam logic [2:0] MULDIV_OP_DIV    = 3'd4;
    localparam logic [2:0] MULDIV_OP_DIVU   = 3'd5;
    localparam logic [2:0] MULDIV_OP_REM    = 3'd6;
    localparam logic [2:0] MULDIV_OP_REMU   = 3'd7;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } muldiv_state_e;

endpackage

// File: rtl/uriscv_muldiv_negate.sv
// Conditional two's-complement negate. It is purely combinational and applies no backpressure.
// It is used to take operand magnitudes and to apply the final result sign.
module uriscv_muldiv_negate #(
    parameter int W = 32
) (
    input  logic         neg,
    input  logic [W-1:0] val,
    output logic [W-1:0] res
);

    assign res = neg ? ((~val) + W'(1)) : val;

endmodule

// File: rtl/uriscv_muldiv.sv
// Iterative RV32M/RV64M multiply/divide: radix-2 shift-add multiply and restoring divide, one bit per clock.
// Latency is XLEN+1 cycles from accept, or 1 cycle for special divides when EARLY_OUT is set. The result is held until ready_i.
module uriscv_muldiv
    import uriscv_defs::*;
#(
    parameter int XLEN      = 32,
    parameter bit EARLY_OUT = 1'b1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            valid_i,
    input  logic [2:0]      op_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    input  logic            kill_i,
    output logic            ready_o,
    output logic            valid_o,
    output logic [XLEN-1:0] result_o,
    input  logic            ready_i
);

    localparam int CW = $clog2(XLEN);

    muldiv_state_e state_q, state_d;

    logic [2:0]      op_q;
    logic            neg_q;
    logic            special_q;
    logic [XLEN-1:0] spec_res_q;
    logic [XLEN:0]   acc_q;
    logic [XLEN-1:0] lo_q;
    logic [XLEN-1:0] opnd_q;
    logic [CW-1:0]   count_q;
    logic [XLEN-1:0] result_q;

    logic            accept, last_step, early_special;
    logic            sign_a, sign_b, neg_in, b_zero, ovf, special_in;
    logic [XLEN-1:0] mag_a, mag_b, spec_res;

    assign ready_o  = (state_q == IDLE);
    assign valid_o  = (state_q == DONE);
    assign result_o = result_q;

    assign accept        = valid_i && ready_o && !kill_i;
    assign last_step     = (count_q == CW'(XLEN - 1));
    assign early_special = EARLY_OUT && special_in;

    // Operand decode at accept: signedness, magnitudes, and the exact RISC-V corner cases.
    assign sign_a = a_i[XLEN-1] && (op_i == MULDIV_OP_MULH || op_i == MULDIV_OP_MULHSU ||
                                    op_i == MULDIV_OP_DIV  || op_i == MULDIV_OP_REM);
    assign sign_b = b_i[XLEN-1] && (op_i == MULDIV_OP_MULH || op_i == MULDIV_OP_DIV ||
                                    op_i == MULDIV_OP_REM);
    assign neg_in = (op_i == MULDIV_OP_REM) ? sign_a : (sign_a ^ sign_b);
    assign b_zero = (b_i == '0);
    assign ovf    = (op_i == MULDIV_OP_DIV || op_i == MULDIV_OP_REM) &&
                    (a_i == {1'b1, {(XLEN-1){1'b0}}}) && (b_i == '1);
    assign special_in = op_i[2] && (b_zero || ovf);

    always_comb begin
        spec_res = '0;
        if (b_zero) begin
            spec_res = op_i[1] ? a_i : '1;
        end else begin
            spec_res = op_i[1] ? '0 : a_i;
        end
    end

    uriscv_muldiv_negate #(.W(XLEN)) u_neg_a (.neg(sign_a), .val(a_i), .res(mag_a));
    uriscv_muldiv_negate #(.W(XLEN)) u_neg_b (.neg(sign_b), .val(b_i), .res(mag_b));

    // One iteration. Multiply: acc is the running high half and lo shifts the multiplier out.
    // Divide: acc is the partial remainder and lo shifts the dividend out and the quotient in.
    logic [XLEN:0]     mul_sum, div_shift, div_diff, nxt_acc;
    logic [XLEN-1:0]   nxt_lo, div_val, final_res;
    logic [2*XLEN-1:0] fix_in, fix_out;

    assign mul_sum   = acc_q + (lo_q[0] ? {1'b0, opnd_q} : '0);
    assign div_shift = {acc_q[XLEN-1:0], lo_q[XLEN-1]};
    assign div_diff  = div_shift - {1'b0, opnd_q};

    always_comb begin
        nxt_acc = '0;
        nxt_lo  = '0;
        if (op_q[2]) begin
            nxt_acc = div_diff[XLEN] ? div_shift : div_diff;
            nxt_lo  = {lo_q[XLEN-2:0], ~div_diff[XLEN]};
        end else begin
            nxt_acc = {1'b0, mul_sum[XLEN:1]};
            nxt_lo  = {mul_sum[0], lo_q[XLEN-1:1]};
        end
    end

    // The sign fix runs on the last step's output, so the result is ready the cycle DONE starts.
    assign div_val = op_q[1] ? nxt_acc[XLEN-1:0] : nxt_lo;
    assign fix_in  = op_q[2] ? {{XLEN{1'b0}}, div_val} : {nxt_acc[XLEN-1:0], nxt_lo};

    uriscv_muldiv_negate #(.W(2*XLEN)) u_neg_res (.neg(neg_q), .val(fix_in), .res(fix_out));

    always_comb begin
        final_res = '0;
        if (special_q) begin
            final_res = spec_res_q;
        end else if (op_q == MULDIV_OP_MUL || op_q[2]) begin
            final_res = fix_out[XLEN-1:0];
        end else begin
            final_res = fix_out[2*XLEN-1:XLEN];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = early_special ? DONE : CALC;
                end
            end
            CALC: begin
                if (kill_i) begin
                    state_d = IDLE;
                end else if (last_step) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (kill_i || ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            op_q       <= '0;
            neg_q      <= 1'b0;
            special_q  <= 1'b0;
            spec_res_q <= '0;
            acc_q      <= '0;
            lo_q       <= '0;
            opnd_q     <= '0;
            count_q    <= '0;
            result_q   <= '0;
        end else if (accept) begin
            op_q       <= op_i;
            neg_q      <= neg_in;
            special_q  <= special_in;
            spec_res_q <= spec_res;
            acc_q      <= '0;
            lo_q       <= op_i[2] ? mag_a : mag_b;
            opnd_q     <= op_i[2] ? mag_b : mag_a;
            count_q    <= '0;
            if (early_special) begin
                result_q <= spec_res;
            end
        end else if (state_q == CALC && !kill_i) begin
            acc_q <= nxt_acc;
            lo_q  <= nxt_lo;
            if (last_step) begin
                result_q <= final_res;
            end else begin
                count_q <= count_q + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_uriscv_muldiv.sv
// Scoreboarded bench for uriscv_muldiv. It runs a 32-bit early-out instance with directed vectors
// and a 64-bit full-latency instance against a reference model.
module tb_uriscv_muldiv;
    import uriscv_defs::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        v32, k32, ri32, ro32, vo32;
    logic [2:0]  op32;
    logic [31:0] a32, b32, r32;

    logic        v64, k64, ri64, ro64, vo64;
    logic [2:0]  op64;
    logic [63:0] a64, b64, r64;

    uriscv_muldiv #(.XLEN(32), .EARLY_OUT(1'b1)) dut32 (
        .clk_i(clk), .rst_i(rst), .valid_i(v32), .op_i(op32), .a_i(a32), .b_i(b32),
        .kill_i(k32), .ready_o(ro32), .valid_o(vo32), .result_o(r32), .ready_i(ri32)
    );

    uriscv_muldiv #(.XLEN(64), .EARLY_OUT(1'b0)) dut64 (
        .clk_i(clk), .rst_i(rst), .valid_i(v64), .op_i(op64), .a_i(a64), .b_i(b64),
        .kill_i(k64), .ready_o(ro64), .valid_o(vo64), .result_o(r64), .ready_i(ri64)
    );

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] e;
        int          lat;
    } vec_t;

    logic [31:0] sb32[$];
    logic [63:0] sb64[$];
    int n_cmp = 0;
    int n_err = 0;

    function automatic logic [63:0] model64(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
        logic [127:0] as_, au, bs, bu, p;
        logic         b0, ov;
        as_ = {{64{a[63]}}, a};
        au  = {64'd0, a};
        bs  = {{64{b[63]}}, b};
        bu  = {64'd0, b};
        b0  = (b == 64'd0);
        ov  = (a == 64'h8000_0000_0000_0000) && (b == 64'hFFFF_FFFF_FFFF_FFFF);
        p   = '0;
        case (op)
            MULDIV_OP_MUL:    begin p = au * bu;  return p[63:0];   end
            MULDIV_OP_MULH:   begin p = as_ * bs; return p[127:64]; end
            MULDIV_OP_MULHSU: begin p = as_ * bu; return p[127:64]; end
            MULDIV_OP_MULHU:  begin p = au * bu;  return p[127:64]; end
            MULDIV_OP_DIV:    return b0 ? 64'hFFFF_FFFF_FFFF_FFFF : ov ? a : 64'($signed(a) / $signed(b));
            MULDIV_OP_DIVU:   return b0 ? 64'hFFFF_FFFF_FFFF_FFFF : a / b;
            MULDIV_OP_REM:    return b0 ? a : ov ? 64'd0 : 64'($signed(a) % $signed(b));
            default:          return b0 ? a : a % b;
        endcase
    endfunction

    task automatic send32(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        int n = 0;
        while (!ro32 && n < 200) begin @(negedge clk); n++; end
        op32 = op; a32 = a; b32 = b; v32 = 1'b1;
        @(negedge clk);
        v32 = 1'b0;
    endtask

    task automatic wait32(output logic [31:0] res, output int lat);
        lat = 1;
        while (!vo32 && lat < 200) begin @(negedge clk); lat++; end
        res = vo32 ? r32 : 'x;
    endtask

    task automatic ack32();
        ri32 = 1'b1;
        @(negedge clk);
        ri32 = 1'b0;
    endtask

    task automatic send64(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
        int n = 0;
        while (!ro64 && n < 300) begin @(negedge clk); n++; end
        op64 = op; a64 = a; b64 = b; v64 = 1'b1;
        @(negedge clk);
        v64 = 1'b0;
    endtask

    task automatic wait64(output logic [63:0] res, output int lat);
        lat = 1;
        while (!vo64 && lat < 300) begin @(negedge clk); lat++; end
        res = vo64 ? r64 : 'x;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++; if (ro32 !== 1'b1)  begin n_err++; $display("FAIL reset ready32 got %b want 1", ro32); end
        n_cmp++; if (vo32 !== 1'b0)  begin n_err++; $display("FAIL reset valid32 got %b want 0", vo32); end
        n_cmp++; if (r32 !== 32'd0)  begin n_err++; $display("FAIL reset result32 got %h want 0", r32); end
        n_cmp++; if (ro64 !== 1'b1)  begin n_err++; $display("FAIL reset ready64 got %b want 1", ro64); end
        n_cmp++; if (vo64 !== 1'b0)  begin n_err++; $display("FAIL reset valid64 got %b want 0", vo64); end
        n_cmp++; if (r64 !== 64'd0)  begin n_err++; $display("FAIL reset result64 got %h want 0", r64); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_arith32();
        vec_t v[16];
        logic [31:0] res, exp;
        int lat;
        v[0]  = '{MULDIV_OP_MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33};
        v[1]  = '{MULDIV_OP_MULH,   32'h80000000, 32'h80000000, 32'h40000000, 33};
        v[2]  = '{MULDIV_OP_MULHU,  32'h80000000, 32'h80000000, 32'h40000000, 33};
        v[3]  = '{MULDIV_OP_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33};
        v[4]  = '{MULDIV_OP_MUL,    32'd0,        32'd12345,    32'd0,        33};
        v[5]  = '{MULDIV_OP_DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33};
        v[6]  = '{MULDIV_OP_REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33};
        v[7]  = '{MULDIV_OP_DIVU,   32'd7,        32'd2,        32'd3,        33};
        v[8]  = '{MULDIV_OP_REMU,   32'd7,        32'd2,        32'd1,        33};
        v[9]  = '{MULDIV_OP_REM,    32'd7,        32'hFFFFFFFE, 32'd1,        33};
        v[10] = '{MULDIV_OP_DIVU,   32'd5,        32'd0,        32'hFFFFFFFF, 1};
        v[11] = '{MULDIV_OP_REM,    32'd5,        32'd0,        32'd5,        1};
        v[12] = '{MULDIV_OP_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1};
        v[13] = '{MULDIV_OP_REM,    32'h80000000, 32'hFFFFFFFF, 32'd0,        1};
        v[14] = '{MULDIV_OP_DIV,    32'hFFFFFFFB, 32'd0,        32'hFFFFFFFF, 1};
        v[15] = '{MULDIV_OP_REMU,   32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 1};
        for (int i = 0; i < 16; i++) begin
            sb32.push_back(v[i].e);
            send32(v[i].op, v[i].a, v[i].b);
            wait32(res, lat);
            exp = sb32.pop_front();
            n_cmp++; if (res !== exp) begin n_err++; $display("FAIL arith[%0d] result got %h want %h", i, res, exp); end
            n_cmp++; if (lat != v[i].lat) begin n_err++; $display("FAIL arith[%0d] latency got %0d want %0d", i, lat, v[i].lat); end
            ack32();
        end
    endtask

    task automatic test_hold();
        logic [31:0] res, exp;
        int lat;
        sb32.push_back(32'd15);
        send32(MULDIV_OP_MUL, 32'd3, 32'd5);
        wait32(res, lat);
        exp = sb32.pop_front();
        n_cmp++; if (res !== exp) begin n_err++; $display("FAIL hold result got %h want %h", res, exp); end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({vo32, ro32, r32} !== {1'b1, 1'b0, exp}) begin
                n_err++; $display("FAIL hold cycle %0d valid=%b ready=%b result=%h want 1 0 %h", i, vo32, ro32, r32, exp);
            end
        end
        ack32();
    endtask

    task automatic test_kill();
        logic [31:0] res, exp;
        int lat;
        bit seen;
        send32(MULDIV_OP_DIVU, 32'd100, 32'd7);
        repeat (10) @(negedge clk);
        k32 = 1'b1;
        @(negedge clk);
        k32 = 1'b0;
        n_cmp++; if ({ro32, vo32} !== 2'b10) begin n_err++; $display("FAIL kill_calc ready/valid got %b%b want 10", ro32, vo32); end
        seen = 1'b0;
        repeat (40) begin @(negedge clk); if (vo32) seen = 1'b1; end
        n_cmp++; if (seen) begin n_err++; $display("FAIL kill_calc valid_o rose after kill got 1 want 0"); end
        op32 = MULDIV_OP_DIVU; a32 = 32'd9; b32 = 32'd3; v32 = 1'b1; k32 = 1'b1;
        @(negedge clk);
        v32 = 1'b0; k32 = 1'b0;
        n_cmp++; if (ro32 !== 1'b1) begin n_err++; $display("FAIL kill_idle accepted ready got %b want 1", ro32); end
        send32(MULDIV_OP_MUL, 32'd2, 32'd3);
        wait32(res, lat);
        k32 = 1'b1;
        @(negedge clk);
        k32 = 1'b0;
        n_cmp++; if ({ro32, vo32} !== 2'b10) begin n_err++; $display("FAIL kill_done ready/valid got %b%b want 10", ro32, vo32); end
        sb32.push_back(32'd2);
        send32(MULDIV_OP_REMU, 32'd100, 32'd7);
        wait32(res, lat);
        exp = sb32.pop_front();
        n_cmp++; if (res !== exp) begin n_err++; $display("FAIL kill_next result got %h want %h", res, exp); end
        ack32();
    endtask

    task automatic test_back_to_back();
        vec_t v[3];
        logic [31:0] res, exp;
        int lat;
        v[0] = '{MULDIV_OP_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33};
        v[1] = '{MULDIV_OP_DIV,   32'd100,      32'hFFFFFFF9, 32'hFFFFFFF2, 33};
        v[2] = '{MULDIV_OP_REM,   32'hFFFFFF9C, 32'd7,        32'hFFFFFFFE, 33};
        for (int i = 0; i < 3; i++) begin
            sb32.push_back(v[i].e);
            send32(v[i].op, v[i].a, v[i].b);
            wait32(res, lat);
            exp = sb32.pop_front();
            n_cmp++; if (res !== exp) begin n_err++; $display("FAIL b2b[%0d] result got %h want %h", i, res, exp); end
            ri32 = 1'b1;
            n_cmp++; if (ro32 !== 1'b0) begin n_err++; $display("FAIL b2b[%0d] ready during handshake got %b want 0", i, ro32); end
            @(negedge clk);
            ri32 = 1'b0;
            n_cmp++; if (ro32 !== 1'b1) begin n_err++; $display("FAIL b2b[%0d] ready after handshake got %b want 1", i, ro32); end
        end
    endtask

    task automatic test_async_reset();
        logic [31:0] res, exp;
        int lat;
        send32(MULDIV_OP_MUL, 32'd6, 32'd7);
        repeat (5) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        n_cmp++; if ({ro32, vo32} !== 2'b10) begin n_err++; $display("FAIL arst ready/valid got %b%b want 10", ro32, vo32); end
        n_cmp++; if (r32 !== 32'd0) begin n_err++; $display("FAIL arst result got %h want 0", r32); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        sb32.push_back(32'd42);
        send32(MULDIV_OP_MUL, 32'd6, 32'd7);
        wait32(res, lat);
        exp = sb32.pop_front();
        n_cmp++; if (res !== exp) begin n_err++; $display("FAIL arst_next result got %h want %h", res, exp); end
        ack32();
    endtask

    task automatic test_rand64();
        logic [63:0] a, b, res, exp;
        logic [2:0]  op;
        int lat, sel;
        for (int i = 0; i < 44; i++) begin
            op  = 3'($urandom_range(0, 7));
            a   = {$urandom, $urandom};
            b   = {$urandom, $urandom};
            sel = $urandom_range(0, 9);
            if (i == 0 || sel == 0) b = 64'd0;
            if ((i == 1 || sel == 1) && op[2]) begin a = 64'h8000_0000_0000_0000; b = '1; end
            if (sel == 2) b = {32'd0, 32'($urandom_range(1, 1000))};
            if (i == 1) op = MULDIV_OP_DIV;
            sb64.push_back(model64(op, a, b));
            send64(op, a, b);
            wait64(res, lat);
            exp = sb64.pop_front();
            n_cmp++; if (res !== exp) begin n_err++; $display("FAIL rand64[%0d] op=%0d a=%h b=%h got %h want %h", i, op, a, b, res, exp); end
            n_cmp++; if (lat != 65) begin n_err++; $display("FAIL rand64[%0d] latency got %0d want 65", i, lat); end
            ri64 = 1'b1;
            @(negedge clk);
            ri64 = 1'b0;
        end
    endtask

    initial begin
        rst = 1'b1;
        v32 = 1'b0; k32 = 1'b0; ri32 = 1'b0; op32 = '0; a32 = '0; b32 = '0;
        v64 = 1'b0; k64 = 1'b0; ri64 = 1'b0; op64 = '0; a64 = '0; b64 = '0;
        test_reset();
        test_arith32();
        test_hold();
        test_kill();
        test_back_to_back();
        test_async_reset();
        test_rand64();
        n_cmp++;
        if (sb32.size() + sb64.size() != 0) begin
            n_err++; $display("FAIL scoreboard leftover got %0d want 0", sb32.size() + sb64.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
